// File: rtl/uart_loopback_system.sv
// Tester UART on a valid/ready register bus, serially cross-wired to an emulator UART that
// sends ENQ after reset, echoes bytes through a 4-deep FIFO and raises trap after echoing EOT.

// Generic FIFO: push/pop valid-ready, registered storage.
// Latency: pushed data visible on pop_dat the cycle after the push.
// Backpressure: push_rdy low while full, pop_vld low while empty.
module fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_vld,
  output logic         push_rdy,
  input  logic [W-1:0] push_dat,
  output logic         pop_vld,
  input  logic         pop_rdy,
  output logic [W-1:0] pop_dat
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push_fire, pop_fire;

  assign push_rdy  = (count != (AW+1)'(DEPTH));
  assign pop_vld   = (count != '0);
  assign pop_dat   = mem[rd_ptr];
  assign push_fire = push_vld && push_rdy;
  assign pop_fire  = pop_vld && pop_rdy;

  always_ff @(posedge clk) begin
    if (push_fire) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
      if (push_fire && !pop_fire)      count <= count + 1'b1;
      else if (!push_fire && pop_fire) count <= count - 1'b1;
    end
  end
endmodule

// 8N1 serial transmitter, LSB first, each bit lasts div cycles.
// Latency: start bit drives txd the cycle after tx_vld is accepted.
// Backpressure: tx_rdy low from acceptance until the stop bit has completed.
module uart_tx (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [15:0] div,
  input  logic        tx_vld,
  input  logic [7:0]  tx_dat,
  output logic        tx_rdy,
  output logic        txd
);
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  tx_state_t   state, state_nxt;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        bit_end;

  assign bit_end = ({1'b0, cnt} + 17'd1) >= {1'b0, div};
  assign tx_rdy  = (state == TX_IDLE);
  assign txd     = (state == TX_START) ? 1'b0 :
                   (state == TX_DATA)  ? shreg[0] : 1'b1;

  always_comb begin
    state_nxt = state;
    case (state)
      TX_IDLE:  if (tx_vld) state_nxt = TX_START;
      TX_START: if (bit_end) state_nxt = TX_DATA;
      TX_DATA:  if (bit_end && bit_idx == 3'd7) state_nxt = TX_STOP;
      TX_STOP:  if (bit_end) state_nxt = TX_IDLE;
      default:  state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state   <= TX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state <= state_nxt;
      if (state == TX_IDLE) begin
        cnt     <= '0;
        bit_idx <= '0;
        if (tx_vld) shreg <= tx_dat;
      end else if (bit_end) begin
        cnt <= '0;
        if (state == TX_DATA) begin
          shreg   <= {1'b0, shreg[7:1]};
          bit_idx <= bit_idx + 1'b1;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// 8N1 serial receiver: falling-edge start detect, mid-bit sampling, framing-error discard.
// Latency: rx_vld pulses one cycle at the middle of the stop bit.
// Backpressure: none; the consumer must take rx_dat in the rx_vld cycle.
module uart_rx (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] div,
  input  logic        rxd,
  output logic        rx_vld,
  output logic [7:0]  rx_dat
);
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t   state, state_nxt;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        rxd_s, rxd_p;
  logic        bit_end, mid_hit;

  assign bit_end = ({1'b0, cnt} + 17'd1) >= {1'b0, div};
  assign mid_hit = cnt >= (div >> 1);
  assign rx_dat  = shreg;

  always_comb begin
    state_nxt = state;
    rx_vld    = 1'b0;
    if (!en) begin
      state_nxt = RX_IDLE;
    end else begin
      case (state)
        RX_IDLE:  if (rxd_p && !rxd_s) state_nxt = RX_START;
        // A start bit that is high again at mid-bit was a glitch
        RX_START: if (mid_hit) state_nxt = rxd_s ? RX_IDLE : RX_DATA;
        RX_DATA:  if (bit_end && bit_idx == 3'd7) state_nxt = RX_STOP;
        RX_STOP: begin
          if (bit_end) begin
            state_nxt = RX_IDLE;
            rx_vld    = rxd_s;
          end
        end
        default:  state_nxt = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_s <= 1'b1;
      rxd_p <= 1'b1;
    end else begin
      rxd_s <= rxd;
      rxd_p <= rxd_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        RX_START: cnt <= mid_hit ? '0 : cnt + 1'b1;
        RX_DATA, RX_STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (state == RX_DATA) begin
              shreg   <= {rxd_s, shreg[7:1]};
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt     <= '0;
          bit_idx <= '0;
        end
      endcase
    end
  end
endmodule

// Bus-mapped tester UART with DIV/TXEN/RXEN registers and a single-byte receive holding register.
// Latency: uart_ready pulses the cycle after uart_valid is sampled; writes land on that edge.
// Backpressure: none on the bus; TXDATA writes while not txready are dropped.
module uart_bus_tester #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 3,
  parameter int DIV_RST = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_valid,
  input  logic [ADDR_W-1:0] uart_addr,
  input  logic [DATA_W-1:0] uart_wdata,
  input  logic [3:0]        uart_wstrb,
  output logic [DATA_W-1:0] uart_rdata,
  output logic              uart_ready,
  output logic              txd,
  input  logic              rxd
);
  logic [15:0]       div_q;
  logic              txen, rxen, rxready;
  logic [7:0]        rxdata;
  logic              wr, rd, soft_clr, txready, tx_rdy, tx_vld, rx_vld;
  logic [7:0]        rx_dat;
  logic [DATA_W-1:0] rd_mux;
  logic              unused_wdata;

  assign unused_wdata = ^uart_wdata;
  assign wr       = uart_valid && (uart_wstrb != 4'd0);
  assign rd       = uart_valid && (uart_wstrb == 4'd0);
  assign soft_clr = wr && (uart_addr == ADDR_W'(0)) && uart_wdata[0];
  assign txready  = txen && tx_rdy;
  assign tx_vld   = wr && (uart_addr == ADDR_W'(2)) && txready;

  uart_tx u_tx (
    .clk(clk), .rst(rst), .clr(soft_clr), .div(div_q),
    .tx_vld(tx_vld), .tx_dat(uart_wdata[7:0]), .tx_rdy(tx_rdy), .txd(txd)
  );

  uart_rx u_rx (
    .clk(clk), .rst(rst), .clr(soft_clr), .en(rxen), .div(div_q),
    .rxd(rxd), .rx_vld(rx_vld), .rx_dat(rx_dat)
  );

  always_comb begin
    rd_mux = '0;
    case (uart_addr)
      ADDR_W'(1): rd_mux = DATA_W'(div_q);
      ADDR_W'(3): rd_mux = DATA_W'(txen);
      ADDR_W'(4): rd_mux = DATA_W'(rxen);
      ADDR_W'(5): rd_mux = DATA_W'(txready);
      ADDR_W'(6): rd_mux = DATA_W'(rxready);
      ADDR_W'(7): rd_mux = DATA_W'(rxdata);
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      uart_ready <= 1'b0;
      uart_rdata <= '0;
      div_q      <= 16'(DIV_RST);
      txen       <= 1'b0;
      rxen       <= 1'b0;
      rxready    <= 1'b0;
      rxdata     <= '0;
    end else begin
      uart_ready <= uart_valid;
      uart_rdata <= rd ? rd_mux : '0;
      if (wr) begin
        case (uart_addr)
          ADDR_W'(1): begin
            if (uart_wstrb[0]) div_q[7:0]  <= uart_wdata[7:0];
            if (uart_wstrb[1]) div_q[15:8] <= uart_wdata[15:8];
          end
          ADDR_W'(3): txen <= uart_wdata[0];
          ADDR_W'(4): rxen <= uart_wdata[0];
          default: ;
        endcase
      end
      // New byte beats a concurrent RXDATA read so it is never lost
      if (soft_clr) begin
        rxready <= 1'b0;
        rxdata  <= '0;
      end else if (rx_vld) begin
        rxready <= 1'b1;
        rxdata  <= rx_dat;
      end else if (rd && uart_addr == ADDR_W'(7)) begin
        rxready <= 1'b0;
      end
    end
  end
endmodule

// SoC-emulator UART: ENQ after 4 bit-times, echo via 4-deep FIFO, trap after EOT echo.
// Latency: echo starts as soon as the transmitter is free after the byte is received.
// Backpressure: bytes arriving while the FIFO is full are dropped.
module uart_emulator #(
  parameter int DIV = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic rxd,
  output logic txd,
  output logic trap
);
  typedef enum logic [1:0] {EMU_BOOT, EMU_IDLE, EMU_ECHO, EMU_DONE} emu_state_t;
  localparam logic [31:0] BOOT_LAST = 32'(4*DIV - 1);

  emu_state_t  state, state_nxt;
  logic [31:0] boot_cnt;
  logic        tx_vld, tx_rdy, rx_vld;
  logic [7:0]  tx_dat, rx_dat, fifo_dat;
  logic        fifo_push, fifo_push_rdy, fifo_pop, fifo_pop_vld;

  uart_tx u_tx (
    .clk(clk), .rst(rst), .clr(1'b0), .div(16'(DIV)),
    .tx_vld(tx_vld), .tx_dat(tx_dat), .tx_rdy(tx_rdy), .txd(txd)
  );

  uart_rx u_rx (
    .clk(clk), .rst(rst), .clr(1'b0), .en(1'b1), .div(16'(DIV)),
    .rxd(rxd), .rx_vld(rx_vld), .rx_dat(rx_dat)
  );

  fifo #(.W(8), .DEPTH(4)) u_fifo (
    .clk(clk), .rst(rst),
    .push_vld(fifo_push), .push_rdy(fifo_push_rdy), .push_dat(rx_dat),
    .pop_vld(fifo_pop_vld), .pop_rdy(fifo_pop), .pop_dat(fifo_dat)
  );

  assign trap = (state == EMU_DONE);

  always_comb begin
    state_nxt = state;
    tx_vld    = 1'b0;
    tx_dat    = fifo_dat;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    case (state)
      EMU_BOOT: begin
        if (boot_cnt == BOOT_LAST) begin
          tx_vld    = 1'b1;
          tx_dat    = 8'h05;
          state_nxt = EMU_IDLE;
        end
      end
      EMU_IDLE: begin
        fifo_push = rx_vld && fifo_push_rdy;
        fifo_pop  = fifo_pop_vld && tx_rdy;
        tx_vld    = fifo_pop;
        if (rx_vld && rx_dat == 8'h04) state_nxt = EMU_ECHO;
      end
      EMU_ECHO: begin
        // Drain what is queued (EOT last); trap once its stop bit has gone out
        fifo_pop = fifo_pop_vld && tx_rdy;
        tx_vld   = fifo_pop;
        if (!fifo_pop_vld && tx_rdy) state_nxt = EMU_DONE;
      end
      default: state_nxt = EMU_DONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMU_BOOT;
      boot_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == EMU_BOOT) boot_cnt <= boot_cnt + 1'b1;
    end
  end
endmodule

// Top: tester txd drives emulator rxd and emulator txd drives tester rxd.
module uart_loopback_system #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int FREQ   = 100000000,
  parameter int BAUD   = 5000000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              trap,
  input  logic              uart_valid,
  input  logic [ADDR_W-1:0] uart_addr,
  input  logic [DATA_W-1:0] uart_wdata,
  input  logic [3:0]        uart_wstrb,
  output logic [DATA_W-1:0] uart_rdata,
  output logic              uart_ready
);
  localparam int DIV = FREQ / BAUD;

  logic tester_txd, emu_txd;

  uart_bus_tester #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIV_RST(DIV)) u_tester (
    .clk(clk), .rst(rst),
    .uart_valid(uart_valid), .uart_addr(uart_addr), .uart_wdata(uart_wdata),
    .uart_wstrb(uart_wstrb), .uart_rdata(uart_rdata), .uart_ready(uart_ready),
    .txd(tester_txd), .rxd(emu_txd)
  );

  uart_emulator #(.DIV(DIV)) u_emu (
    .clk(clk), .rst(rst), .rxd(tester_txd), .txd(emu_txd), .trap(trap)
  );
endmodule

// File: tb/tb_uart_loopback_system.sv
// Directed bench: drives the tester UART bus, scoreboards expected echo bytes against RXDATA reads.
module tb_uart_loopback_system;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trap;
  logic        uart_valid = 1'b0;
  logic [2:0]  uart_addr  = '0;
  logic [31:0] uart_wdata = '0;
  logic [3:0]  uart_wstrb = '0;
  logic [31:0] uart_rdata;
  logic        uart_ready;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic        ack_seen;
  logic [7:0]  exp_q[$];
  logic [31:0] r;
  int          c0;

  uart_loopback_system #(.DATA_W(32), .ADDR_W(3), .FREQ(100000000), .BAUD(5000000)) dut (
    .clk(clk), .rst(rst), .trap(trap),
    .uart_valid(uart_valid), .uart_addr(uart_addr), .uart_wdata(uart_wdata),
    .uart_wstrb(uart_wstrb), .uart_rdata(uart_rdata), .uart_ready(uart_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] rv);
    @(negedge clk);
    uart_valid = 1'b1; uart_addr = a; uart_wdata = d; uart_wstrb = s;
    @(negedge clk);
    rv = uart_rdata; ack_seen = uart_ready;
    uart_valid = 1'b0; uart_wstrb = '0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    bus(a, d, 4'hf, dummy);
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] rv);
    bus(a, 32'd0, 4'h0, rv);
  endtask

  task automatic send(input string tag, input logic [7:0] b, input bit expect_echo);
    logic [31:0] rv;
    rv = '0;
    for (int n = 0; n < 400; n++) begin
      rd(3'd5, rv);
      if (rv[0]) break;
    end
    check({tag, "_txready"}, rv, 32'd1);
    wr(3'd2, {24'd0, b});
    if (expect_echo) exp_q.push_back(b);
  endtask

  task automatic rx_byte(input string tag);
    logic [31:0] rv, ev;
    rv = '0;
    for (int n = 0; n < 400; n++) begin
      rd(3'd6, rv);
      if (rv[0]) break;
    end
    check({tag, "_rxready"}, rv, 32'd1);
    if (rv[0]) begin
      rd(3'd7, rv);
      ev = (exp_q.size() != 0) ? {24'd0, exp_q.pop_front()} : 32'hffff_ffff;
      check({tag, "_rxdata"}, rv, ev);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", uart_ready, 1'b0);
    check("rst_rdata", uart_rdata, 32'd0);
    check("rst_trap", trap, 1'b0);
    rst = 1'b0;

    wr(3'd1, 32'd20);
    wr(3'd3, 32'd1);
    wr(3'd4, 32'd1);
    exp_q.push_back(8'h05);

    rd(3'd1, r);
    check("div_rd", r, 32'd20);
    check("ack_hi", ack_seen, 1'b1);
    @(negedge clk);
    check("ack_lo", uart_ready, 1'b0);
    rd(3'd3, r); check("txen_rd", r, 32'd1);
    rd(3'd4, r); check("rxen_rd", r, 32'd1);
    rd(3'd5, r); check("txready_rd", r, 32'd1);
    rd(3'd6, r); check("rxready_early", r, 32'd0);

    // Valid held two cycles: two back-to-back acknowledges, then ready drops
    @(negedge clk);
    uart_valid = 1'b1; uart_addr = 3'd1; uart_wstrb = 4'h0;
    @(negedge clk);
    check("b2b_ack1", uart_ready, 1'b1);
    check("b2b_dat1", uart_rdata, 32'd20);
    @(negedge clk);
    check("b2b_ack2", uart_ready, 1'b1);
    uart_valid = 1'b0;
    @(negedge clk);
    check("b2b_drop", uart_ready, 1'b0);

    rx_byte("enq");
    rd(3'd6, r); check("rxready_clr", r, 32'd0);

    send("s41", 8'h41, 1'b1);
    c0 = cyc;
    rd(3'd5, r); check("txready_busy", r, 32'd0);
    for (int n = 0; n < 300; n++) begin
      rd(3'd5, r);
      if (r[0]) break;
    end
    check("tx_time_ok", ((cyc - c0) >= 195 && (cyc - c0) <= 215) ? 32'd1 : 32'd0, 32'd1);
    rx_byte("echo41");

    send("s61", 8'h61, 1'b1);
    send("s62", 8'h62, 1'b1);
    send("s63", 8'h63, 1'b1);
    rx_byte("echo61");
    rx_byte("echo62");
    rx_byte("echo63");

    send("s70", 8'h70, 1'b1);
    wr(3'd2, 32'h71);
    rx_byte("echo70");
    repeat (600) @(negedge clk);
    rd(3'd6, r); check("no_echo71", r, 32'd0);

    wr(3'd0, 32'd1);
    rd(3'd1, r); check("softrst_div", r, 32'd20);
    rd(3'd3, r); check("softrst_txen", r, 32'd1);
    rd(3'd6, r); check("softrst_rxready", r, 32'd0);

    send("s04", 8'h04, 1'b1);
    rx_byte("eot");
    for (int n = 0; n < 300 && !trap; n++) @(negedge clk);
    check("trap_set", trap, 1'b1);

    wr(3'd2, 32'h55);
    repeat (800) @(negedge clk);
    rd(3'd6, r); check("done_no_echo", r, 32'd0);
    check("trap_sticky", trap, 1'b1);
    check("sb_empty", exp_q.size(), 32'd0);

    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst2_trap", trap, 1'b0);
    check("rst2_ready", uart_ready, 1'b0);
    rst = 1'b0;
    rd(3'd3, r); check("rst2_txen", r, 32'd0);
    rd(3'd1, r); check("rst2_div", r, 32'd20);
    wr(3'd4, 32'd1);
    exp_q.push_back(8'h05);
    rx_byte("enq2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
